decode_issue: RTL
=================

// Module: decode_issue
// PURPOSE
// - Front end of the execute stage: takes 32-bit instruction words over valid/ready and decodes them.
// - Drives the execute-stage operands: opcode, fs, sh, a, b and the destination register.
// - Reads two register-file ports and forwards same-cycle writeback data.
// - Inserts a one-cycle bubble on a load-use hazard and squashes its stage on a branch flush.
// PARAMETERS
// DATA_W    32  operand / instruction width
// REG_AW     5  register address width (32 registers, r0 reads as zero)
// LU_STALL   1  1 = enforce load-use bubble; 0 = never stall (memory returns same-cycle)
// PORTS
// clk        in   1       rising-edge clock
// rst        in   1       synchronous, active-high reset
// in_valid   in   1       instruction word valid
// in_ready   out  1       stage can accept an instruction this cycle
// in_inst    in   DATA_W  instruction word
// flush      in   1       branch/jump taken: discard held and incoming instruction
// ra_addr    out  REG_AW  regfile read port A address (combinational from in_inst)
// rb_addr    out  REG_AW  regfile read port B address
// ra_data    in   DATA_W  regfile port A data (combinational)
// rb_data    in   DATA_W  regfile port B data
// wb_en      in   1       writeback enable this cycle
// wb_addr    in   REG_AW  writeback register
// wb_data    in   DATA_W  writeback data
// out_valid  out  1       decoded bundle valid for execute
// out_ready  in   1       execute accepts bundle
// opcode     out  7       inst[31:25]
// fs         out  4       inst[9:6]
// sh         out  5       inst[4:0]
// a          out  DATA_W  operand A (rs = inst[19:15])
// b          out  DATA_W  operand B: reg inst[14:10], or {16'b0,inst[15:0]} for immediate opcodes
// rd         out  REG_AW  destination inst[24:20]
// is_load    out  1       opcode == LD
// BEHAVIOUR
// - Reset: out_valid=0; opcode,fs,sh,a,b,rd,is_load=0; load-pending flag=0. in_ready=1 on first post-reset cycle.
// - Single output register stage; latency 1 clk from accept to out_valid.
// - Input accept = in_valid & in_ready.
//   - in_ready = (~out_valid | out_ready) & ~stall & ~flush.
//   - On accept, all outputs load; else outputs hold while out_valid & ~out_ready.
// - Output transfer = out_valid & out_ready. After transfer with no new accept, out_valid -> 0.
// - b operand:
//   - Raw low 16 bits (zero-filled) for ADI,SBI,ANI,ORI,XRI,AIU,SIU; execute applies sign extension.
//   - Register data for all other opcodes.
// - Operand read: r0 -> 0. Else if wb_en & wb_addr==addr & addr!=0 -> wb_data; else regfile data.
// - Load-use (LU_STALL=1):
//   - Hazard: out_valid & is_load & rd!=0 & (rd==rs | (rd==rb & b uses a register)).
//   - On hazard, stall=1, in_ready=0 for exactly 1 cycle after the load transfers.
//   - During that cycle out_valid=0 (bubble); instruction is accepted the next cycle.
// - flush (priority over everything):
//   - Next edge: out_valid=0, pending-load flag=0; in_inst that cycle is not accepted.
//   - Register contents other than valid are don't-care.
// - NOP (opcode 0) is decoded and issued like any instruction; no special-casing.
// - Reset mid-stall or mid-hold: same as reset; held bundle is dropped.
// TESTING
// - Reset: rst=1 two cycles -> out_valid=0, a=b=0, in_ready=1 on first cycle after rst falls.
// - ADD r3,r1,r2 with regfile r1=5,r2=7 -> next cycle out_valid=1, a=5, b=7, rd=3, opcode=ADD.
// - ADI r4,r1,0xFFFF -> b=32'h0000FFFF; same cycle wb_en r1=9 -> a=9 (forwarded).
// - LD r5 then ADD r6,r5,r0 back-to-back -> one cycle out_valid=0 between them; ADD issues next cycle.
// - Backpressure: out_ready=0 for 3 cycles -> outputs stable, in_ready=0; released -> next instruction issues.
// - flush with out_valid=1 and in_valid=1 -> next cycle out_valid=0, incoming word not issued.

Source files
------------

// File: rtl/decode_issue.sv
// decode_issue: decodes instruction words into execute-stage operands with forwarding, load-use bubble and flush
module decode_issue #(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int LU_STALL = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_inst,
    input  logic              flush,
    output logic [REG_AW-1:0] ra_addr,
    output logic [REG_AW-1:0] rb_addr,
    input  logic [DATA_W-1:0] ra_data,
    input  logic [DATA_W-1:0] rb_data,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [6:0]        opcode,
    output logic [3:0]        fs,
    output logic [4:0]        sh,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [REG_AW-1:0] rd,
    output logic              is_load
);
    localparam logic [6:0] OP_LD  = 7'h08;
    localparam logic [6:0] OP_ADI = 7'h10;
    localparam logic [6:0] OP_SBI = 7'h11;
    localparam logic [6:0] OP_ANI = 7'h12;
    localparam logic [6:0] OP_ORI = 7'h13;
    localparam logic [6:0] OP_XRI = 7'h14;
    localparam logic [6:0] OP_AIU = 7'h15;
    localparam logic [6:0] OP_SIU = 7'h16;
    logic [6:0]        op_in;
    logic              imm_in;
    logic              stall;
    logic              accept;
    logic              ld_pend;
    logic [DATA_W-1:0] a_in;
    logic [DATA_W-1:0] b_reg;
    logic [DATA_W-1:0] b_in;
    assign op_in   = in_inst[31:25];
    assign ra_addr = in_inst[19:15];
    assign rb_addr = in_inst[14:10];
    assign imm_in  = op_in inside {OP_ADI, OP_SBI, OP_ANI, OP_ORI, OP_XRI, OP_AIU, OP_SIU};
    // ld_pend mirrors "a load sits in the output register"; flush clears it with valid
    always_comb begin
        a_in     = ra_addr == '0 ? '0 : (wb_en && wb_addr == ra_addr) ? wb_data : ra_data;
        b_reg    = rb_addr == '0 ? '0 : (wb_en && wb_addr == rb_addr) ? wb_data : rb_data;
        b_in     = imm_in ? DATA_W'(in_inst[15:0]) : b_reg;
        stall    = LU_STALL != 0 && ld_pend && rd != '0 && (rd == ra_addr || (rd == rb_addr && !imm_in));
        in_ready = (!out_valid || out_ready) && !stall && !flush;
        accept   = in_valid && in_ready;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            ld_pend   <= 1'b0;
            opcode    <= '0;
            fs        <= '0;
            sh        <= '0;
            a         <= '0;
            b         <= '0;
            rd        <= '0;
            is_load   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            ld_pend   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            ld_pend   <= op_in == OP_LD;
            opcode    <= op_in;
            fs        <= in_inst[9:6];
            sh        <= in_inst[4:0];
            a         <= a_in;
            b         <= b_in;
            rd        <= in_inst[24:20];
            is_load   <= op_in == OP_LD;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            ld_pend   <= 1'b0;
        end
    end
endmodule
